irq_pending_arbiter: RTL and testbench
======================================

Name: irq_pending_arbiter

Overview:
Sequential request-capture stage that feeds the 8-to-3 priority encode function. It latches rising edges on 8 request lines into pending bits and applies a per-source mask. It selects the highest-index unmasked pending source, then presents its 3-bit ID with a valid/ack handshake until the consumer acknowledges it. Sits between raw event lines and the downstream ID consumer.

Parameters:
NSRC, 8, number of request sources; fixed at 8 for this revision.
IDW, 3, width of the source ID; equals log2(NSRC).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
req_in  input  8  raw request lines; bit 7 highest priority
mask_in  input  8  mask value; 1 = source masked
mask_we  input  1  load mask_in into mask register this cycle
irq_ack  input  1  consumer acknowledge of presented ID
ovf_clr  input  1  clear sticky overflow flag
irq_valid  output  1  ID presented and stable
irq_id  output  3  ID of presented source (7..0)
pending  output  8  current pending register
mask  output  8  current mask register
overflow  output  1  sticky: edge arrived on an already-pending source

Behaviour:
- Reset, with rst=1 at a clk edge:
  - pending=0, mask=8'hFF (all masked), irq_valid=0, irq_id=0, overflow=0, state=IDLE.
  - req_q loads req_in, so levels held across reset create no events.
- Edge detect:
  - req_q <= req_in every cycle.
  - edge[i] = req_in[i] & ~req_q[i].
  - A pending bit sets on the clk edge at which its edge is seen.
- Masking:
  - Masked sources still set pending; they are only excluded from selection.
  - eligible = pending & ~mask.
  - mask_we updates mask on the next edge.
- Selection: the highest set index of eligible wins (bit 7 over bit 0).
- FSM, 3 states:
  - IDLE: irq_valid=0. If eligible != 0, register irq_id = winner and go PRESENT.
  - PRESENT: irq_valid=1, and irq_id is held stable regardless of new requests or mask changes. On irq_ack=1: clear pending[irq_id] and go CLEAR.
  - CLEAR: irq_valid=0 for exactly one cycle, then go IDLE.
- Latency:
  - req_in rises, sampled at edge k -> pending set after edge k.
  - irq_valid=1 after edge k+1 (2 cycles), provided the source is eligible and the FSM is IDLE.
- Back-to-back: minimum of 3 cycles between successive irq_valid rising edges (PRESENT -> CLEAR -> IDLE -> PRESENT).
- Simultaneous events:
  - New edge on bit irq_id in the same cycle as its ack: set wins, pending stays 1, no overflow.
  - Edge on a bit already pending and not being cleared that cycle: overflow <= 1.
  - ovf_clr and an overflow event in the same cycle: set wins.
- irq_ack outside PRESENT is ignored, with no pending change.
- A presented ID is never withdrawn, even if its source is masked while PRESENT.
- Reset asserted mid-handshake: all state returns to reset values on that edge; irq_valid drops the same edge.
- All outputs are registered. No combinational path from inputs to irq_valid or irq_id.

Test Plan:
- Reset then mask_we with mask_in=8'h00; pulse req_in[3] 0->1 -> pending=8'h08 next cycle; irq_valid=1, irq_id=3 one cycle later; irq_ack -> pending=0, irq_valid=0 for 1 cycle.
- req_in=8'h21 rising together with mask=0 -> irq_id=5 first; after ack and CLEAR, irq_id=0 presented; pending sequence 8'h21 -> 8'h01 -> 8'h00.
- mask=8'h80, req_in[7] and req_in[2] rise -> pending=8'h84, irq_id=2; then unmask bit 7 while PRESENT -> irq_id stays 2 until ack, then 7 is presented.
- With bit 4 pending, drop req_in[4] and raise it again -> overflow=1; ovf_clr -> overflow=0; raise it again in the same cycle as irq_ack of ID 4 -> pending[4] stays 1, overflow=0.
- Hold req_in=8'hFF through reset and release -> pending=0, irq_valid=0 (no edge events).
- Assert rst while irq_valid=1 with irq_id=6 -> next cycle irq_valid=0, pending=0, mask=8'hFF, overflow=0.

Source files
------------

// File: rtl/irq_pending_arbiter.sv
// irq_pending_arbiter: captures rising edges on eight request lines into
// sticky pending bits, applies a per-source mask, and presents the ID of the
// highest-index eligible source to a downstream consumer with a valid/ack
// handshake. A sticky overflow flag records edges on already-pending sources.
module irq_pending_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_in,
  input  logic [7:0] mask_in,
  input  logic       mask_we,
  input  logic       irq_ack,
  input  logic       ovf_clr,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic [7:0] pending,
  output logic [7:0] mask,
  output logic       overflow
);

  localparam int NSRC = 8;
  localparam int IDW  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    CLEAR   = 2'd2
  } state_t;

  state_t          state;
  logic [NSRC-1:0] req_q;
  logic [NSRC-1:0] edge_det;
  logic [NSRC-1:0] clr_vec;
  logic [NSRC-1:0] eligible;
  logic [IDW-1:0]  winner;
  logic            ovf_event;

  // Edge detect, ack-driven clear vector and overflow event for this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    clr_vec   = '0;
    edge_det  = req_in & ~req_q;
    if (state == PRESENT && irq_ack)
      clr_vec[irq_id] = 1'b1;
    // An edge on the bit being acknowledged re-arms it and is not an overflow.
    ovf_event = |(edge_det & pending & ~clr_vec);
    eligible  = pending & ~mask;
  end

  // Priority select: scan upward so the highest set index overwrites lower ones.
  always_comb begin
    winner = '0;
    for (int i = 0; i < NSRC; i++)
      if (eligible[i])
        winner = IDW'(i);
  end

  // Request history, pending bits, mask and sticky overflow.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    req_q <= req_in;
    if (rst) begin
      pending  <= '0;
      mask     <= '1;
      overflow <= 1'b0;
    end else begin
      // Set wins over clear when an edge and an ack hit the same bit.
      pending <= (pending & ~clr_vec) | edge_det;
      if (mask_we)
        mask <= mask_in;
      if (ovf_event)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  // Handshake FSM with registered valid/ID; the presented ID is frozen until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            irq_id    <= winner;
            irq_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (irq_ack) begin
            irq_valid <= 1'b0;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          irq_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          irq_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Directed bench for irq_pending_arbiter: hand-computed expectations for
// capture latency, priority, masking, handshake, overflow and reset cases.
module tb_irq_pending_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mask_in;
  logic       mask_we;
  logic       irq_ack;
  logic       ovf_clr;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic [7:0] mask;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  irq_pending_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask_in   (mask_in),
    .mask_we   (mask_we),
    .irq_ack   (irq_ack),
    .ovf_clr   (ovf_clr),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .mask      (mask),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_in = 8'h00; mask_in = 8'h00; mask_we = 1'b0;
    irq_ack = 1'b0; ovf_clr = 1'b0;

    // Reset state
    tick();
    check("rst_pending", pending, 8'h00);
    check("rst_mask", mask, 8'hFF);
    check("rst_valid", {7'd0, irq_valid}, 8'h00);
    check("rst_id", {5'd0, irq_id}, 8'h00);
    check("rst_ovf", {7'd0, overflow}, 8'h00);
    rst = 1'b0;

    // Single source 3, 2-cycle latency, ack clears
    mask_we = 1'b1; mask_in = 8'h00; tick(); mask_we = 1'b0;
    check("t1_mask", mask, 8'h00);
    req_in = 8'h08; tick();
    check("t1_pend", pending, 8'h08);
    check("t1_valid_early", {7'd0, irq_valid}, 8'h00);
    tick();
    check("t1_valid", {7'd0, irq_valid}, 8'h01);
    check("t1_id", {5'd0, irq_id}, 8'h03);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("t1_pend_clr", pending, 8'h00);
    check("t1_valid_clr", {7'd0, irq_valid}, 8'h00);
    tick();
    check("t1_valid_idle", {7'd0, irq_valid}, 8'h00);
    req_in = 8'h00; tick();

    // Two sources together: 5 first, then 0
    req_in = 8'h21; tick();
    check("t2_pend", pending, 8'h21);
    tick();
    check("t2_id5", {5'd0, irq_id}, 8'h05);
    check("t2_valid5", {7'd0, irq_valid}, 8'h01);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("t2_pend01", pending, 8'h01);
    check("t2_valid_clr", {7'd0, irq_valid}, 8'h00);
    tick();
    check("t2_valid_idle", {7'd0, irq_valid}, 8'h00);
    tick();
    check("t2_id0", {5'd0, irq_id}, 8'h00);
    check("t2_valid0", {7'd0, irq_valid}, 8'h01);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("t2_pend00", pending, 8'h00);
    tick();
    req_in = 8'h00; tick();

    // Masked bit 7 still pends; unmask while presenting 2 does not preempt
    mask_we = 1'b1; mask_in = 8'h80; tick(); mask_we = 1'b0;
    req_in = 8'h84; tick();
    check("t3_pend", pending, 8'h84);
    tick();
    check("t3_id2", {5'd0, irq_id}, 8'h02);
    mask_we = 1'b1; mask_in = 8'h00; tick(); mask_we = 1'b0;
    check("t3_hold_id", {5'd0, irq_id}, 8'h02);
    check("t3_hold_valid", {7'd0, irq_valid}, 8'h01);
    tick();
    check("t3_hold_id2", {5'd0, irq_id}, 8'h02);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("t3_pend80", pending, 8'h80);
    tick(); tick();
    check("t3_id7", {5'd0, irq_id}, 8'h07);
    check("t3_valid7", {7'd0, irq_valid}, 8'h01);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("t3_pend00", pending, 8'h00);
    tick();
    req_in = 8'h00; tick();

    // Overflow on re-edge of pending bit 4; clear; set-wins cases
    req_in = 8'h10; tick();
    tick();
    check("t4_id4", {5'd0, irq_id}, 8'h04);
    req_in = 8'h00; tick();
    req_in = 8'h10; tick();
    check("t4_ovf_set", {7'd0, overflow}, 8'h01);
    check("t4_pend", pending, 8'h10);
    req_in = 8'h00; tick();
    req_in = 8'h10; ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("t4_ovf_setwins", {7'd0, overflow}, 8'h01);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("t4_ovf_clr", {7'd0, overflow}, 8'h00);
    req_in = 8'h00; tick();
    req_in = 8'h10; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("t4_ack_rearm_pend", pending, 8'h10);
    check("t4_ack_rearm_ovf", {7'd0, overflow}, 8'h00);
    check("t4_ack_valid", {7'd0, irq_valid}, 8'h00);
    tick(); tick();
    check("t4_re_present", {5'd0, irq_id}, 8'h04);
    check("t4_re_valid", {7'd0, irq_valid}, 8'h01);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("t4_pend_clr", pending, 8'h00);
    tick();

    // Levels held through reset create no events; ack outside PRESENT ignored
    rst = 1'b1; req_in = 8'hFF; tick(); tick(); rst = 1'b0;
    tick();
    check("t5_pend", pending, 8'h00);
    check("t5_valid", {7'd0, irq_valid}, 8'h00);
    req_in = 8'h00; tick();
    req_in = 8'h01; tick();
    check("t5_pend_masked", pending, 8'h01);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("t5_ack_ignored", pending, 8'h01);
    check("t5_valid_masked", {7'd0, irq_valid}, 8'h00);

    // Reset mid-handshake with overflow set
    rst = 1'b1; req_in = 8'h00; tick(); rst = 1'b0;
    mask_we = 1'b1; mask_in = 8'h00; tick(); mask_we = 1'b0;
    req_in = 8'h40; tick();
    tick();
    check("t6_id6", {5'd0, irq_id}, 8'h06);
    check("t6_valid", {7'd0, irq_valid}, 8'h01);
    req_in = 8'h00; tick();
    req_in = 8'h40; tick();
    check("t6_ovf", {7'd0, overflow}, 8'h01);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_rst_valid", {7'd0, irq_valid}, 8'h00);
    check("t6_rst_pend", pending, 8'h00);
    check("t6_rst_mask", mask, 8'hFF);
    check("t6_rst_ovf", {7'd0, overflow}, 8'h00);
    check("t6_rst_id", {5'd0, irq_id}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
